kf_stream_loader: RTL

Upstream feeder for `kf_top`. Replaces hand-sequenced `START`/`DATA_IN` driving with an autonomous stream source. Holds the 20-word initialisation image (x, P, Phi, Q, H, R, G, u) in a local configuration bank and buffers incoming measurements in a FIFO. On `run`, it issues the exact cycle-contiguous load burst, then presents one measurement per filter iteration on the core's measurement request.

---
 rtl/kf_stream_loader_if.sv | 25 ++
 rtl/kf_stream_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kf_stream_loader_if.sv
// Stream interface between kf_stream_loader and its neighbours: the
// measurement push port (valid/data/ready) and the kf_top feed
// (kf_meas_req in, kf_start/kf_data out).
// slave  : the loader side.
// master : the environment side (measurement source and kf_top).
interface kf_stream_loader_if #(
  parameter int unsigned W = 24
);
  logic         meas_valid;
  logic [W-1:0] meas_data;
  logic         meas_ready;
  logic         kf_meas_req;
  logic         kf_start;
  logic [W-1:0] kf_data;

  modport master (
    output meas_valid, meas_data, kf_meas_req,
    input  meas_ready, kf_start, kf_data
  );

  modport slave (
    input  meas_valid, meas_data, kf_meas_req,
    output meas_ready, kf_start, kf_data
  );
endinterface

// File: rtl/kf_stream_loader.sv
// kf_stream_loader: autonomous feeder for kf_top.
// Holds the NCFG-word init image in a config bank and buffers measurements
// in a DEPTH-entry FIFO. On run it emits the contiguous load burst
// (kf_start on word 0), then one measurement per kf_meas_req.
// Optional build macro: KF_LOADER_TWOS_EN -- meas_data is two's complement
// and is converted to sign-magnitude at the FIFO input (saturating the most
// negative value). Without it meas_data is stored unchanged.
module kf_stream_loader #(
  parameter int unsigned W     = 24,
  parameter int unsigned NCFG  = 20,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ITW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [W-1:0]         cfg_wdata,
  input  logic                 run,
  input  logic [ITW-1:0]       num_iters,
  kf_stream_loader_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 underflow,
  output logic [ITW-1:0]       iter_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
    S_MEAS0,
    S_RUN
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_bank [NCFG];
  logic [W-1:0]   r_mem  [DEPTH];
  logic [AW:0]    r_wptr, r_rptr;
  logic [4:0]     r_k, w_k_nxt, w_k_inc;
  logic           r_kf_start, w_kf_start_nxt;
  logic [W-1:0]   r_kf_data, w_kf_data_nxt;
  logic           r_done, w_done_nxt;
  logic           r_underflow, w_underflow_nxt;
  logic [ITW-1:0] r_iter_count, w_iter_nxt, w_iter_inc;
  logic [ITW-1:0] r_num_iters, w_num_nxt;

  logic           w_empty, w_full, w_push, w_pop;
  logic [W-1:0]   w_push_word, w_head;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push   = bus.meas_valid & bus.meas_ready;
  assign w_head   = r_mem[r_rptr[AW-1:0]];
  assign w_k_inc  = r_k + 5'd1;
  assign w_iter_inc = r_iter_count + ITW'(1);

  assign bus.meas_ready = ~w_full & ~rst;
  assign bus.kf_start   = r_kf_start;
  assign bus.kf_data    = r_kf_data;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign underflow      = r_underflow;
  assign iter_count     = r_iter_count;

`ifdef KF_LOADER_TWOS_EN
  logic [W-2:0] w_mag;
  assign w_mag = -bus.meas_data[W-2:0];

  // Two's complement to sign-magnitude; -2^(W-1) saturates to full-scale negative
  always_comb begin
    w_push_word = bus.meas_data;
    if (bus.meas_data[W-1]) begin
      if (bus.meas_data[W-2:0] == '0) w_push_word = '1;
      else                            w_push_word = {1'b1, w_mag};
    end
  end
`else
  assign w_push_word = bus.meas_data;
`endif

  // Config bank: zeroed on reset, writable in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCFG; i++) r_bank[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < NCFG)) begin
      r_bank[cfg_addr] <= cfg_wdata;
    end
  end

  // FIFO storage (contents need no reset; pointers define occupancy)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_push_word;
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Session state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_kf_start   <= 1'b0;
      r_kf_data    <= '0;
      r_done       <= 1'b0;
      r_underflow  <= 1'b0;
      r_iter_count <= '0;
      r_num_iters  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_kf_start   <= w_kf_start_nxt;
      r_kf_data    <= w_kf_data_nxt;
      r_done       <= w_done_nxt;
      r_underflow  <= w_underflow_nxt;
      r_iter_count <= w_iter_nxt;
      r_num_iters  <= w_num_nxt;
    end
  end

  // Next-state logic; kf_data is computed one cycle ahead so the output is a flop
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_kf_start_nxt  = 1'b0;
    w_kf_data_nxt   = r_kf_data;
    w_done_nxt      = 1'b0;
    w_underflow_nxt = r_underflow;
    w_iter_nxt      = r_iter_count;
    w_num_nxt       = r_num_iters;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_kf_data_nxt = '0;
        if (run && (num_iters != '0)) begin
          w_state_nxt     = S_ARM;
          w_num_nxt       = num_iters;
          w_underflow_nxt = 1'b0;
          w_iter_nxt      = '0;
        end
      end
      S_ARM: begin
        w_kf_data_nxt = '0;
        if (!w_empty) begin
          w_state_nxt    = S_LOAD;
          w_k_nxt        = '0;
          w_kf_start_nxt = 1'b1;
          w_kf_data_nxt  = r_bank[0];
        end
      end
      S_LOAD: begin
        // Leaving LOAD pops the first measurement so it shows during MEAS0
        if (r_k == 5'(NCFG - 1)) begin
          w_state_nxt   = S_MEAS0;
          w_pop         = 1'b1;
          w_kf_data_nxt = w_head;
        end else begin
          w_k_nxt       = w_k_inc;
          w_kf_data_nxt = r_bank[w_k_inc];
        end
      end
      S_MEAS0: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.kf_meas_req) begin
          w_iter_nxt = w_iter_inc;
          if (w_iter_inc < r_num_iters) begin
            if (!w_empty) begin
              w_pop         = 1'b1;
              w_kf_data_nxt = w_head;
            end else begin
              w_underflow_nxt = 1'b1;
            end
          end else begin
            w_kf_data_nxt = '0;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_kf_data_nxt = '0;
      end
    endcase
  end

endmodule
